// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_main between NUM_REQ requesters: latches the winning
// command, sequences the transfer, returns tagged read data, then cools down; a watchdog bounds each transfer.
module spi_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = $clog2(NUM_REQ),
  parameter int ADDR_WIDTH      = 6,
  parameter int DATA_WIDTH      = 8,
  parameter int COOLDOWN_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_mode,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic                             rsp_valid,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_error,
  output logic                             busy,
  output logic                             spi_en,
  output logic                             spi_mode,
  output logic [ADDR_WIDTH-1:0]            spi_rw_addr,
  output logic [DATA_WIDTH-1:0]            spi_write_data,
  output logic                             spi_write_valid,
  input  logic                             spi_cs,
  input  logic [DATA_WIDTH-1:0]            spi_read_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]       CD_LAST  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(NUM_REQ - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LAUNCH     = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] COOLDOWN   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [CW-1:0]         cd_q, cd_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  grant_any;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   scan_idx;

  // First valid requester starting at the round-robin pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Gated by rst_n so no accept pulse leaks out while held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tmo_d       = tmo_q;
    cd_d        = cd_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          id_d    = grant_idx;
          mode_d  = req_mode[grant_idx];
          addr_d  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          ptr_d   = (grant_idx == ID_LAST) ? '0 : grant_idx + ID_WIDTH'(1);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START, WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        // Completion takes priority over a timeout landing in the same cycle.
        if (state_q == WAIT_DONE && spi_cs) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mode_q ? '0 : spi_read_data;
          cd_d        = '0;
          state_d     = COOLDOWN;
        end else if (tmo_q + TW'(1) == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          cd_d        = '0;
          state_d     = COOLDOWN;
        end else if (state_q == WAIT_START && !spi_cs) begin
          state_d = WAIT_DONE;
        end
      end
      COOLDOWN: begin
        if (cd_q == CD_LAST) state_d = IDLE;
        else                 cd_d    = cd_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tmo_q       <= '0;
      cd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tmo_q       <= tmo_d;
      cd_q        <= cd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign spi_en          = (state_q == LAUNCH);
  assign spi_mode        = mode_q;
  assign spi_write_valid = mode_q;
  assign spi_rw_addr     = addr_q;
  assign spi_write_data  = wdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = id_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_error       = rsp_error_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: reads, writes, round-robin order, timeout,
// mid-transfer reset and grant deferral during cooldown.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [3:0]  req_mode = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        spi_en;
  logic        spi_mode;
  logic [5:0]  spi_rw_addr;
  logic [7:0]  spi_write_data;
  logic        spi_write_valid;
  logic        spi_cs = 1'b1;
  logic [7:0]  spi_read_data = '0;

  int n_chk = 0;
  int n_pass = 0;
  int en_cnt = 0;
  int rsp_cnt = 0;
  int rdy0_cnt = 0;

  spi_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(6), .DATA_WIDTH(8),
    .COOLDOWN_CYCLES(20), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .spi_en(spi_en), .spi_mode(spi_mode), .spi_rw_addr(spi_rw_addr),
    .spi_write_data(spi_write_data), .spi_write_valid(spi_write_valid),
    .spi_cs(spi_cs), .spi_read_data(spi_read_data)
  );

  // Clock and event counters
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spi_en) en_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (req_ready[0]) rdy0_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for an accept pulse, returns it and the cycles waited, then steps into LAUNCH.
  task automatic wait_grant(input string tag, output logic [3:0] rdy, output int n);
    bit found;
    found = 1'b0;
    rdy = '0;
    n = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      #1;
      if (req_ready != 4'b0000) begin
        found = 1'b1;
        rdy = req_ready;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_grant_seen"}, 32'(found), 32'd1);
    @(negedge clk);
    chk({tag, "_launch_en"}, 32'(spi_en), 32'd1);
  endtask

  // Slave model: CS low for a few cycles, then high with read data; captures the response.
  task automatic serve(input string tag, input logic [7:0] rd,
                       output logic [1:0] id, output logic [7:0] data, output logic err);
    int lat;
    lat = 0;
    id = '0;
    data = '0;
    err = 1'b0;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    spi_read_data = rd;
    spi_cs = 1'b1;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        id = rsp_id;
        data = rsp_data;
        err = rsp_error;
      end
    end
    chk({tag, "_rsp_latency"}, 32'(lat), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    chk({tag, "_idle_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [3:0] rdy;
    logic [3:0] exp_rdy;
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
    int         n;
    int         en0;
    int         rdy0;
    int         rsp0;
    int         k;

    // Reset state, with requests present to confirm no accept leaks out
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(spi_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_addr", 32'(spi_rw_addr), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single read from requester 0
    en0 = en_cnt;
    rdy0 = rdy0_cnt;
    req_mode[0] = 1'b0;
    req_addr[0 +: 6] = 6'h2A;
    req_valid = 4'b0001;
    wait_grant("t1", rdy, n);
    chk("t1_ready", 32'(rdy), 32'h1);
    chk("t1_addr", 32'(spi_rw_addr), 32'h2A);
    chk("t1_mode", 32'(spi_mode), 32'd0);
    chk("t1_wvalid", 32'(spi_write_valid), 32'd0);
    req_valid = '0;
    serve("t1", 8'hC3, id, data, err);
    chk("t1_id", 32'(id), 32'd0);
    chk("t1_data", 32'(data), 32'hC3);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_en_pulses", 32'(en_cnt - en0), 32'd1);
    chk("t1_ready_pulses", 32'(rdy0_cnt - rdy0), 32'd1);
    repeat (19) @(negedge clk);
    chk("t1_busy_cooldown", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // 2: write from requester 2, command held through cooldown
    req_mode[2] = 1'b1;
    req_addr[12 +: 6] = 6'h05;
    req_wdata[16 +: 8] = 8'h7E;
    req_valid = 4'b0100;
    wait_grant("t2", rdy, n);
    chk("t2_ready", 32'(rdy), 32'h4);
    chk("t2_mode", 32'(spi_mode), 32'd1);
    chk("t2_wvalid", 32'(spi_write_valid), 32'd1);
    chk("t2_addr", 32'(spi_rw_addr), 32'h05);
    chk("t2_wdata", 32'(spi_write_data), 32'h7E);
    req_valid = '0;
    serve("t2", 8'hAA, id, data, err);
    chk("t2_id", 32'(id), 32'd2);
    chk("t2_data", 32'(data), 32'd0);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_wdata_rsp", 32'(spi_write_data), 32'h7E);
    repeat (19) @(negedge clk);
    chk("t2_addr_end_cd", 32'(spi_rw_addr), 32'h05);
    chk("t2_wvalid_end_cd", 32'(spi_write_valid), 32'd1);
    @(negedge clk);
    chk("t2_busy_done", 32'(busy), 32'd0);

    // 3: all requesters held valid from a fresh pointer
    do_reset();
    req_mode = 4'b0000;
    req_addr = {6'h33, 6'h22, 6'h11, 6'h00};
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      wait_grant("t3", rdy, n);
      chk("t3_ready", 32'(rdy), 32'(exp_rdy));
      if (i == 7) req_valid = '0;
      serve("t3", 8'h10 + 8'(i), id, data, err);
      chk("t3_id", 32'(id), 32'(i % 4));
      chk("t3_data", 32'(data), 32'(8'h10 + 8'(i)));
    end
    wait_idle("t3");

    // 4: no slave activity -> timeout on requester 1, then requester 2 proceeds
    req_mode[1] = 1'b0;
    req_valid = 4'b0010;
    wait_grant("t4", rdy, n);
    chk("t4_ready", 32'(rdy), 32'h2);
    req_valid = '0;
    k = 0;
    for (int j = 1; j <= 100 && k == 0; j++) begin
      @(negedge clk);
      if (rsp_valid) k = j;
    end
    chk("t4_timeout_cycles", 32'(k), 32'd64);
    chk("t4_err", 32'(rsp_error), 32'd1);
    chk("t4_id", 32'(rsp_id), 32'd1);
    chk("t4_data", 32'(rsp_data), 32'd0);
    req_mode[2] = 1'b0;
    req_valid = 4'b0100;
    wait_grant("t4b", rdy, n);
    chk("t4b_ready", 32'(rdy), 32'h4);
    chk("t4b_wait", 32'(n), 32'd20);
    req_valid = '0;
    serve("t4b", 8'h5A, id, data, err);
    chk("t4b_id", 32'(id), 32'd2);
    chk("t4b_data", 32'(data), 32'h5A);
    chk("t4b_err", 32'(err), 32'd0);
    wait_idle("t4b");

    // 5: reset during WAIT_DONE abandons the transfer
    req_valid = 4'b0100;
    wait_grant("t5", rdy, n);
    req_valid = '0;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rsp0 = rsp_cnt;
    rst_n = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_en", 32'(spi_en), 32'd0);
    chk("t5_mode", 32'(spi_mode), 32'd0);
    chk("t5_addr", 32'(spi_rw_addr), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_grant("t5b", rdy, n);
    chk("t5_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    chk("t5b_ready", 32'(rdy), 32'h2);
    chk("t5b_wait", 32'(n), 32'd0);
    req_valid = '0;
    serve("t5b", 8'h3C, id, data, err);
    chk("t5b_id", 32'(id), 32'd1);
    chk("t5b_data", 32'(data), 32'h3C);
    chk("t5b_err", 32'(err), 32'd0);
    wait_idle("t5b");

    // 6: requester 3 arrives alongside requester 1's grant; served after cooldown
    do_reset();
    req_mode = 4'b0000;
    req_valid = 4'b1010;
    wait_grant("t6", rdy, n);
    chk("t6_ready", 32'(rdy), 32'h2);
    req_valid = 4'b1000;
    serve("t6", 8'h81, id, data, err);
    chk("t6_id", 32'(id), 32'd1);
    wait_grant("t6b", rdy, n);
    chk("t6b_ready", 32'(rdy), 32'h8);
    chk("t6b_wait", 32'(n), 32'd20);
    req_valid = '0;
    serve("t6b", 8'h99, id, data, err);
    chk("t6b_id", 32'(id), 32'd3);
    chk("t6b_data", 32'(data), 32'h99);
    wait_idle("t6b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
